// File: rtl/divider_control.sv
// rtl/divider_control.sv - sequencing FSM for the long-division datapath
//
// Purpose: accepts a start request, steps the datapath through load,
// normalise (shift left), subtract/shift-right iterations, then captures the
// quotient and remainder and reports done, divide-by-zero and timeout.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start                      division request (honoured in IDLE or DONE)
//   cnt_is_zero, divisor_msb,  registered datapath status flags
//   divisor_is_zero,
//   dvsr_less_than_dvnd
//   quotient_in, remainder_in  datapath result buses
//   init, left, right, sub     one-hot datapath strobes (combinational)
//   busy                       operation in progress
//   done                       one-cycle pulse on entry to DONE
//   div_by_zero, timeout       sticky error flags for the last operation
//   quotient_out,remainder_out registered results of the last operation
//   cycle_count                cycles spent in the last/current operation

module divider_control #(
    parameter int size       = 32,
    parameter int MAX_CYCLES = 4*size+4,
    parameter int CW         = $clog2(MAX_CYCLES+1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            cnt_is_zero,
    input  logic            divisor_msb,
    input  logic            divisor_is_zero,
    input  logic            dvsr_less_than_dvnd,
    input  logic [size-1:0] quotient_in,
    input  logic [size-1:0] remainder_in,
    output logic            init,
    output logic            left,
    output logic            right,
    output logic            sub,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic            timeout,
    output logic [size-1:0] quotient_out,
    output logic [size-1:0] remainder_out,
    output logic [CW-1:0]   cycle_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] STEP  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CYCLES);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       set_dz;
    logic       set_to;
    logic       at_max;
    logic       entering_done;

    assign at_max        = (cycle_count == MAX_CNT);
    assign entering_done = (state_next == DONE) && (state != DONE);
    assign busy          = (state == LOAD) || (state == CHECK) ||
                           (state == NORM) || (state == STEP);

    // Next state and strobe decode. The timeout check comes first in NORM
    // and STEP so that an aborting cycle never issues a strobe.
    always_comb begin
        state_next = state;
        init       = 1'b0;
        left       = 1'b0;
        right      = 1'b0;
        sub        = 1'b0;
        set_dz     = 1'b0;
        set_to     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                init       = 1'b1;
                state_next = CHECK;
            end
            CHECK: begin
                if (divisor_is_zero) begin
                    state_next = DONE;
                    set_dz     = 1'b1;
                end else begin
                    state_next = NORM;
                end
            end
            NORM: begin
                if (at_max) begin
                    state_next = DONE;
                    set_to     = 1'b1;
                end else if (!divisor_msb && dvsr_less_than_dvnd) begin
                    left = 1'b1;
                end else begin
                    state_next = STEP;
                end
            end
            STEP: begin
                if (at_max) begin
                    state_next = DONE;
                    set_to     = 1'b1;
                end else if (dvsr_less_than_dvnd) begin
                    sub = 1'b1;
                end else if (cnt_is_zero) begin
                    state_next = DONE;
                end else begin
                    right = 1'b1;
                end
            end
            DONE: begin
                if (start) state_next = LOAD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
            timeout       <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
            cycle_count   <= '0;
        end else begin
            state <= state_next;
            done  <= entering_done;

            if (state == LOAD) begin
                cycle_count <= '0;
                div_by_zero <= 1'b0;
                timeout     <= 1'b0;
            end else begin
                if ((state == CHECK || state == NORM || state == STEP) && !at_max)
                    cycle_count <= cycle_count + 1'b1;
                if (set_dz) div_by_zero <= 1'b1;
                if (set_to) timeout     <= 1'b1;
            end

            // Results are captured on every entry to DONE, error paths included.
            if (entering_done) begin
                quotient_out  <= quotient_in;
                remainder_out <= remainder_in;
            end
        end
    end

endmodule
